// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue controller: op indices, FSM state
// encoding and op decode helpers.
package alu_issue_pkg;

  localparam int OP_IDX_W    = 4;
  localparam int OP_ONEHOT_W = 9;

  localparam logic [OP_IDX_W-1:0] OP_SUM  = 4'd0;
  localparam logic [OP_IDX_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_IDX_W-1:0] OP_OR   = 4'd2;
  localparam logic [OP_IDX_W-1:0] OP_AND  = 4'd3;
  localparam logic [OP_IDX_W-1:0] OP_NO   = 4'd4;
  localparam logic [OP_IDX_W-1:0] OP_RSF  = 4'd5;
  localparam logic [OP_IDX_W-1:0] OP_LSF  = 4'd6;
  localparam logic [OP_IDX_W-1:0] OP_RLF  = 4'd7;
  localparam logic [OP_IDX_W-1:0] OP_LLF  = 4'd8;
  localparam logic [OP_IDX_W-1:0] OP_LAST = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } issue_state_t;

  // Indices above OP_LAST decode to an all-zero code.
  function automatic logic [OP_ONEHOT_W-1:0] op_to_onehot(input logic [OP_IDX_W-1:0] op);
    logic [OP_ONEHOT_W-1:0] v;
    v = '0;
    if (op <= OP_LAST) v = {{(OP_ONEHOT_W-1){1'b0}}, 1'b1} << op;
    return v;
  endfunction

  function automatic logic op_is_arith(input logic [OP_IDX_W-1:0] op);
    return (op == OP_SUM) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Command buffer for the ALU issue controller: DEPTH x WIDTH synchronous
// FIFO with wrap-bit pointers, full/empty flags and async active-low reset.
module alu_issue_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command-side driver for the one-hot-opcode ALU: buffers commands, holds the
// ALU code for the op's latency, captures the result and returns a response.
// Optional flag outputs (rsp_zero, rsp_neg, sat_overflow) under ALU_ISSUE_FLAGS_EN.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DATA_W    = 10,
  parameter int OP_W      = 9,
  parameter int CMD_DEPTH = 2,
  parameter int ARITH_LAT = 3,
  parameter int LOGIC_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [OP_W-1:0]   alu_code,
  output logic [DATA_W-1:0] alu_imData,
  output logic [DATA_W-1:0] alu_data,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic              rsp_err,
  output logic              busy,
`ifdef ALU_ISSUE_FLAGS_EN
  output logic              rsp_zero,
  output logic              rsp_neg,
  output logic              sat_overflow,
`endif
  output logic [1:0]        dbg_state
);

  // Both ports transfer on a clock edge where valid && ready are high; a
  // producer holds valid and its payload steady until that edge, and ready
  // never depends combinationally on the other side's valid or ready.

  localparam int FIFO_W  = 4 + 2 * DATA_W;
  localparam int MAX_LAT = (ARITH_LAT > LOGIC_LAT) ? ARITH_LAT : LOGIC_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int MSB     = DATA_W - 1;

  issue_state_t r_state;
  issue_state_t w_next_state;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [FIFO_W-1:0] w_fifo_wdata;
  logic [FIFO_W-1:0] w_fifo_rdata;
  logic [3:0]        w_head_op;
  logic [DATA_W-1:0] w_head_a;
  logic [DATA_W-1:0] w_head_b;
  logic              w_head_legal;

  logic [OP_W-1:0]   r_code;
  logic [DATA_W-1:0] r_imdata;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_arith;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_carry;
  logic              r_rsp_err;

`ifdef ALU_ISSUE_FLAGS_EN
  logic r_is_sub;
  logic r_rsp_zero;
  logic r_rsp_neg;
  logic r_sat;
  logic w_sat;
`endif

  assign w_push       = cmd_valid && !w_full;
  assign cmd_ready    = !w_full;
  assign w_fifo_wdata = {cmd_op, cmd_a, cmd_b};
  assign w_pop        = (r_state == ST_IDLE) && !w_empty;

  assign w_head_op    = w_fifo_rdata[FIFO_W-1 -: 4];
  assign w_head_a     = w_fifo_rdata[2*DATA_W-1 -: DATA_W];
  assign w_head_b     = w_fifo_rdata[DATA_W-1:0];
  assign w_head_legal = (w_head_op <= OP_LAST);

  alu_issue_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_push  (w_push),
    .i_wdata (w_fifo_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (!w_empty) w_next_state = w_head_legal ? ST_ISSUE : ST_RESP;
      ST_ISSUE:   if (r_cnt == '0) w_next_state = ST_CAPTURE;
      ST_CAPTURE: w_next_state = ST_RESP;
      ST_RESP:    if (rsp_ready) w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // The code is only presented during ISSUE, so it reads zero in CAPTURE and idle.
  always_comb begin
    rsp_valid = (r_state == ST_RESP);
    busy      = (r_state != ST_IDLE) || !w_empty;
    alu_code  = (r_state == ST_ISSUE) ? r_code : '0;
    dbg_state = r_state;
  end

  assign alu_imData = r_imdata;
  assign alu_data   = r_data;
  assign rsp_data   = r_rsp_data;
  assign rsp_carry  = r_rsp_carry;
  assign rsp_err    = r_rsp_err;

`ifdef ALU_ISSUE_FLAGS_EN
  // SUM overflows on like-signed operands, SUB on unlike-signed ones.
  assign w_sat = r_is_arith &&
                 (r_is_sub ? (r_imdata[MSB] != r_data[MSB])
                           : (r_imdata[MSB] == r_data[MSB])) &&
                 (alu_out[MSB] != r_imdata[MSB]);
  assign rsp_zero     = r_rsp_zero;
  assign rsp_neg      = r_rsp_neg;
  assign sat_overflow = r_sat;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_code      <= '0;
      r_imdata    <= '0;
      r_data      <= '0;
      r_cnt       <= '0;
      r_is_arith  <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_err   <= 1'b0;
`ifdef ALU_ISSUE_FLAGS_EN
      r_is_sub    <= 1'b0;
      r_rsp_zero  <= 1'b0;
      r_rsp_neg   <= 1'b0;
      r_sat       <= 1'b0;
`endif
    end else begin
      if (w_pop) begin
        if (w_head_legal) begin
          r_code     <= OP_W'(op_to_onehot(w_head_op));
          r_imdata   <= w_head_a;
          r_data     <= w_head_b;
          r_is_arith <= op_is_arith(w_head_op);
          r_cnt      <= op_is_arith(w_head_op) ? CNT_W'(ARITH_LAT - 1)
                                               : CNT_W'(LOGIC_LAT - 1);
`ifdef ALU_ISSUE_FLAGS_EN
          r_is_sub   <= (w_head_op == OP_SUB);
`endif
        end else begin
          r_rsp_data  <= '0;
          r_rsp_carry <= 1'b0;
          r_rsp_err   <= 1'b1;
`ifdef ALU_ISSUE_FLAGS_EN
          r_rsp_zero  <= 1'b0;
          r_rsp_neg   <= 1'b0;
          r_sat       <= 1'b0;
`endif
        end
      end
      if ((r_state == ST_ISSUE) && (r_cnt != '0)) r_cnt <= r_cnt - 1'b1;
      if (r_state == ST_CAPTURE) begin
        r_rsp_data  <= alu_out;
        r_rsp_carry <= r_is_arith && alu_carry;
        r_rsp_err   <= 1'b0;
`ifdef ALU_ISSUE_FLAGS_EN
        r_rsp_zero  <= (alu_out == '0);
        r_rsp_neg   <= alu_out[MSB];
        r_sat       <= w_sat;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU, directed latency
// cases, backpressure, mid-op reset, and a randomized run against a reference queue.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

  localparam int DATA_W    = 10;
  localparam int OP_W      = 9;
  localparam int CMD_DEPTH = 2;
  localparam int ARITH_LAT = 3;
  localparam int LOGIC_LAT = 1;
  localparam int W         = DATA_W + 2;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [3:0]        cmd_op = '0;
  logic [DATA_W-1:0] cmd_a = '0;
  logic [DATA_W-1:0] cmd_b = '0;
  logic [OP_W-1:0]   alu_code;
  logic [DATA_W-1:0] alu_imData;
  logic [DATA_W-1:0] alu_data;
  logic [DATA_W-1:0] alu_out;
  logic              alu_carry;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_carry;
  logic              rsp_err;
  logic              busy;
  logic [1:0]        dbg_state;
`ifdef ALU_ISSUE_FLAGS_EN
  logic              rsp_zero;
  logic              rsp_neg;
  logic              sat_overflow;
  logic [2:0]        flg_q[$];
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_rsp    = 0;
  bit rnd_done = 0;
  logic [W-1:0] exp_q[$];

  alu_issue_ctrl #(
    .DATA_W(DATA_W), .OP_W(OP_W), .CMD_DEPTH(CMD_DEPTH),
    .ARITH_LAT(ARITH_LAT), .LOGIC_LAT(LOGIC_LAT)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_code(alu_code), .alu_imData(alu_imData), .alu_data(alu_data),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err), .busy(busy),
`ifdef ALU_ISSUE_FLAGS_EN
    .rsp_zero(rsp_zero), .rsp_neg(rsp_neg), .sat_overflow(sat_overflow),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- ALU behaviour (what the ALU computes per op) ----------------
  function automatic logic [DATA_W:0] alu_ref(input int op, input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [DATA_W:0] r;
    case (op)
      0: r = {1'b0, a} + {1'b0, b};
      1: r = {(a < b), a - b};
      2: r = {1'b0, a | b};
      3: r = {1'b0, a & b};
      4: r = {1'b0, ~a};
      5: r = {a[0], 1'b0, a[DATA_W-1:1]};
      6: r = {a[DATA_W-1], a[DATA_W-2:0], 1'b0};
      7: r = {a[DATA_W-1], a[DATA_W-2:0], a[DATA_W-1]};
      8: r = {a[0], a[0], a[DATA_W-1:1]};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int code_idx(input logic [OP_W-1:0] code);
    int idx = 15;
    int ones = 0;
    for (int i = 0; i < OP_W; i++) if (code[i]) begin idx = i; ones++; end
    return (ones == 1) ? idx : 15;
  endfunction

  // ALU model: a result only appears once the code has been held for the op's latency.
  int alu_hold;
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      alu_out   <= '0;
      alu_carry <= 1'b0;
      alu_hold  <= 0;
    end else if (alu_code != '0) begin
      alu_hold <= alu_hold + 1;
      if (alu_hold + 1 >= ((alu_code[0] || alu_code[1]) ? ARITH_LAT : LOGIC_LAT))
        {alu_carry, alu_out} <= alu_ref(code_idx(alu_code), alu_imData, alu_data);
      else
        {alu_carry, alu_out} <= {1'b1, 10'h155};
    end else begin
      alu_hold <= 0;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] exp_of(input logic [3:0] op, input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
    logic [DATA_W:0] r;
    if (op > 4'd8) return {2'b10, {DATA_W{1'b0}}};
    r = alu_ref(int'(op), a, b);
    return {1'b0, (op <= 4'd1) ? r[DATA_W] : 1'b0, r[DATA_W-1:0]};
  endfunction

`ifdef ALU_ISSUE_FLAGS_EN
  function automatic logic [2:0] flags_of(input logic [3:0] op, input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
    logic [DATA_W:0] r;
    logic sat;
    if (op > 4'd8) return 3'b000;
    r   = alu_ref(int'(op), a, b);
    sat = ((op == 4'd0) && (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1])) ||
          ((op == 4'd1) && (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]));
    return {(r[DATA_W-1:0] == '0), r[DATA_W-1], sat};
  endfunction
`endif

  // ---------------- scoreboard monitor ----------------
  bit prev_hs = 0;
  bit prev_hold = 0;
  logic [W-1:0] held;
  always @(negedge CLK) begin
    if (!RST_N) begin
      prev_hs   = 0;
      prev_hold = 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back(exp_of(cmd_op, cmd_a, cmd_b));
`ifdef ALU_ISSUE_FLAGS_EN
        flg_q.push_back(flags_of(cmd_op, cmd_a, cmd_b));
`endif
      end
      if (prev_hs) check_eq("bubble_after_rsp", rsp_valid, 1'b0);
      if (prev_hold) begin
        check_eq("rsp_valid_held", rsp_valid, 1'b1);
        check_eq("rsp_payload_stable", {rsp_err, rsp_carry, rsp_data}, held);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_rsp", rsp_valid, 1'b0);
        end else begin
          check_eq("rsp_err_carry_data", {rsp_err, rsp_carry, rsp_data}, exp_q.pop_front());
`ifdef ALU_ISSUE_FLAGS_EN
          check_eq("rsp_flags", {rsp_zero, rsp_neg, sat_overflow}, flg_q.pop_front());
`endif
        end
        n_rsp++;
      end
      prev_hs   = rsp_valid && rsp_ready;
      prev_hold = rsp_valid && !rsp_ready;
      held      = {rsp_err, rsp_carry, rsp_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [3:0] op, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b);
    int waited = 0;
    bit acc = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    while (!acc && waited < 200) begin
      @(negedge CLK);
      acc = cmd_ready;
      @(posedge CLK); #1;
      waited++;
    end
    cmd_valid = 1'b0;
    if (!acc) check_eq("cmd_accept_timeout", acc, 1'b1);
  endtask

  // Called one step after the accepting edge; latency 1 is the cycle after accept.
  task automatic measure(input string tag, input logic [OP_W-1:0] code, input int n_exp,
                         input int lat_exp);
    int lat = 1;
    int hits = 0;
    int stray = 0;
    while (!rsp_valid && lat < 40) begin
      if (code != '0 && alu_code == code) hits++;
      else if (alu_code != '0) stray++;
      @(posedge CLK); #1;
      lat++;
    end
    check_eq({tag, "_latency"}, lat, lat_exp);
    check_eq({tag, "_code_cycles"}, hits, n_exp);
    check_eq({tag, "_stray_code"}, stray, 0);
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 500) begin
      @(posedge CLK); #1;
      n++;
    end
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base;
    int n;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("reset_rsp_valid", rsp_valid, 1'b0);
    check_eq("reset_rsp_data", rsp_data, 0);
    check_eq("reset_rsp_carry", rsp_carry, 1'b0);
    check_eq("reset_rsp_err", rsp_err, 1'b0);
    check_eq("reset_alu_code", alu_code, 0);
    check_eq("reset_alu_imData", alu_imData, 0);
    check_eq("reset_alu_data", alu_data, 0);
    check_eq("reset_busy", busy, 1'b0);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check_eq("post_reset_cmd_ready", cmd_ready, 1'b1);

    send_cmd(4'd0, 10'd5, 10'd3);
    measure("sum", 9'h001, 3, 6);
    check_eq("sum_data", rsp_data, 10'd8);
    check_eq("sum_carry", rsp_carry, 1'b0);
    check_eq("sum_err", rsp_err, 1'b0);
    ack();

    send_cmd(4'd3, 10'h3F0, 10'h0FF);
    measure("and", 9'h008, 1, 4);
    check_eq("and_data", rsp_data, 10'h0F0);
    ack();

    send_cmd(4'd12, 10'h3A5, 10'h05A);
    measure("illegal", 9'h000, 0, 2);
    check_eq("illegal_err", rsp_err, 1'b1);
    check_eq("illegal_data", rsp_data, 0);
    check_eq("illegal_carry", rsp_carry, 1'b0);
    ack();

    // Backpressure: one in flight, two queued, then the FIFO is full.
    send_cmd(4'd0, 10'd1, 10'd2);
    send_cmd(4'd0, 10'd100, 10'd27);
    send_cmd(4'd0, 10'h3FF, 10'd1);
    check_eq("bp_cmd_ready_low", cmd_ready, 1'b0);
    repeat (10) @(posedge CLK);
    #1;
    check_eq("bp_rsp_valid", rsp_valid, 1'b1);
    check_eq("bp_first_data", rsp_data, 10'd3);
    check_eq("bp_cmd_ready_still_low", cmd_ready, 1'b0);
    base = n_rsp;
    rsp_ready = 1'b1;
    n = 0;
    while (n_rsp < base + 3 && n < 60) begin
      @(posedge CLK); #1;
      n++;
    end
    check_eq("bp_rsp_count", n_rsp - base, 3);
    wait_idle("bp");

    // Reset in the middle of a SUB issue.
    send_cmd(4'd1, 10'h020, 10'h007);
    @(posedge CLK); #1;
    check_eq("rst_pre_code", alu_code, 9'h002);
    RST_N = 1'b0;
    #1;
    check_eq("rst_alu_code", alu_code, 0);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    exp_q.delete();
`ifdef ALU_ISSUE_FLAGS_EN
    flg_q.delete();
`endif
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    rsp_ready = 1'b0;
    @(posedge CLK); #1;
    check_eq("rst_after_cmd_ready", cmd_ready, 1'b1);
    check_eq("rst_after_rsp_valid", rsp_valid, 1'b0);
    send_cmd(4'd2, 10'h001, 10'h200);
    measure("or_after_reset", 9'h004, 1, 4);
    check_eq("or_after_reset_data", rsp_data, 10'h201);
    ack();

`ifdef ALU_ISSUE_FLAGS_EN
    send_cmd(4'd1, 10'd4, 10'd4);
    measure("sub_zero", 9'h002, 3, 6);
    check_eq("sub_zero_flag", rsp_zero, 1'b1);
    check_eq("sub_neg_flag", rsp_neg, 1'b0);
    ack();
    send_cmd(4'd0, 10'h1FF, 10'd1);
    measure("sum_sat", 9'h001, 3, 6);
    check_eq("sum_sat_flag", sat_overflow, 1'b1);
    ack();
`endif

    // Randomized traffic with random response backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [3:0] op;
          op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge CLK); #1;
          end
          send_cmd(op, DATA_W'($urandom_range(0, 1023)), DATA_W'($urandom_range(0, 1023)));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge CLK); #1;
          rsp_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    rsp_ready = 1'b1;
    wait_idle("random_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Command-side driver for the 10-bit one-hot-opcode ALU. It sits between the instruction path and the ALU.
- Accepts encoded ALU commands over a valid/ready port and buffers them in a small FIFO.
- Drives the ALU's one-hot code and operand buses for the required number of cycles.
- Captures the ALU result and carry, and returns them over a valid/ready response port.
- Only one operation is in the ALU at any time.

Parameters:
- DATA_W, 10, operand/result width; must match the ALU.
- OP_W, 9, width of the one-hot ALU code.
- CMD_DEPTH, 2, command FIFO entries; power of two, >=2.
- ARITH_LAT, 3, cycles alu_code is held for SUM/SUB.
- LOGIC_LAT, 1, cycles alu_code is held for all other ops.

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_op  in  4  op index: 0 SUM, 1 SUB, 2 OR, 3 AND, 4 NO, 5 RSF, 6 LSF, 7 RLF, 8 LLF; 9-15 illegal
- cmd_a  in  DATA_W  first operand (drives ALU imData)
- cmd_b  in  DATA_W  second operand (drives ALU data)
- alu_code  out  OP_W  one-hot code to ALU; zero when idle
- alu_imData  out  DATA_W  operand A to ALU
- alu_data  out  DATA_W  operand B to ALU
- alu_out  in  DATA_W  ALU result
- alu_carry  in  1  ALU carry
- rsp_valid  out  1  response held
- rsp_ready  in  1  response consumed
- rsp_data  out  DATA_W  captured result
- rsp_carry  out  1  captured carry; 0 for non-arith ops
- rsp_err  out  1  illegal op
- busy  out  1  FSM not IDLE, or FIFO not empty

Behaviour:
- Reset: all of the following go to 0 asynchronously, and the FIFO empties.
  - Outputs: rsp_valid, rsp_data, rsp_carry, rsp_err, alu_code, alu_imData, alu_data, busy.
  - cmd_ready goes to 1 after reset releases.
  - Reset mid-operation aborts it with no response. alu_code drops to 0 immediately.
- FIFO: push when cmd_valid && cmd_ready. cmd_ready = !full, registered-state based (no combinational path from rsp_ready). A simultaneous push and pop on a full FIFO is not allowed: ready stays low.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
  - IDLE: if the FIFO is non-empty, pop the head and go to ISSUE at the next edge.
    - Legal op: load alu_code = 1<<op; load operands.
    - Illegal op: skip ISSUE; go to RESP with rsp_err=1, rsp_data=0, rsp_carry=0; alu_code stays 0.
  - ISSUE: alu_code and operands are held constant for exactly N cycles (N = ARITH_LAT for ops 0/1, else LOGIC_LAT), using a down-counter loaded with N-1. On count 0, go to CAPTURE and drive alu_code to 0 from the CAPTURE cycle on.
  - CAPTURE: one cycle. Sample alu_out into rsp_data. Sample alu_carry into rsp_carry for ops 0/1, else 0. rsp_err=0. Go to RESP.
  - RESP: rsp_valid=1. rsp_data, rsp_carry and rsp_err are stable until the handshake. On rsp_valid && rsp_ready, go to IDLE. The next pop happens in IDLE at the earliest, so there is one IDLE bubble between responses.
- Latency, legal op: from FIFO pop to rsp_valid is N+2 cycles; from cmd accept into an empty idle block to rsp_valid is N+3 cycles.
- Illegal op: rsp_valid 2 cycles after accept.
- Operands: alu_imData and alu_data hold their last values outside ISSUE. They are not cleared, which saves toggles.
- Ordering: responses return in command order.

Optional Feature:
- Macro: ALU_ISSUE_FLAGS_EN.
- Defined:
  - Extra outputs rsp_zero (rsp_data==0) and rsp_neg (rsp_data[DATA_W-1]), registered in CAPTURE; both 0 on illegal op and at reset.
  - Extra output sat_overflow: 1 when SUM/SUB operands have equal or opposing signs respectively and the result sign differs.
- Undefined: these ports are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_issue_pkg holds:
  - op index constants (OP_SUM..OP_LLF, OP_LAST=8)
  - a state enum for IDLE/ISSUE/CAPTURE/RESP
  - a function op_to_onehot(op) returning OP_W bits, 0 for illegal
  - a function op_is_arith(op)
- One sub-module, alu_issue_fifo: a synchronous FIFO, CMD_DEPTH x (4+2*DATA_W), with full/empty flags and async active-low reset.

Test Plan:
- SUM: cmd_a=5, cmd_b=3 into idle block -> alu_code=9'h001 for exactly 3 cycles; rsp_valid 6 cycles after accept; rsp_data=8, rsp_carry=0.
- AND: cmd_a=10'h3F0, cmd_b=10'h0FF -> alu_code=9'h008 for 1 cycle; rsp_data=10'h0F0; rsp_valid 4 cycles after accept.
- cmd_op=12 -> alu_code stays 0; rsp_valid 2 cycles after accept, rsp_err=1, rsp_data=0.
- rsp_ready held low while 3 SUMs are sent -> first response held stable; FIFO takes 2, cmd_ready=0; release rsp_ready -> 3 responses in order, with one bubble between each.
- RST_N low during ISSUE of SUB -> alu_code=0 and rsp_valid=0 immediately, FIFO empty; after release, a fresh OR 10'h001|10'h200 returns 10'h201.
- With ALU_ISSUE_FLAGS_EN: SUB 4-4 -> rsp_zero=1, rsp_neg=0; SUM 10'h1FF+1 -> sat_overflow=1.
